// File: rtl/cache_ctrl_fsm_if.sv
// Bus bundle for cache_ctrl_fsm: CPU request/response, cache-array access and memory port.
// The master modport is the environment side (CPU, arrays, memory); the slave modport is the controller.
interface cache_ctrl_fsm_if #(
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 26,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 8
);
   logic                  cpu_req_valid;
   logic                  cpu_req_ready;
   logic                  cpu_req_we;
   logic [ADDR_W-1:0]     cpu_req_addr;
   logic [DATA_W-1:0]     cpu_req_wdata;
   logic                  cpu_resp_valid;
   logic [DATA_W-1:0]     cpu_resp_rdata;
   logic [IDX_W-1:0]      arr_index;
   logic [TAG_W-1:0]      tag_rdata;
   logic                  valid_rdata;
   logic [DATA_W-1:0]     data_rdata;
   logic                  arr_write;
   logic [2**IDX_W-1:0]   line_sel;
   logic [TAG_W-1:0]      tag_wdata;
   logic [DATA_W-1:0]     data_wdata;
   logic                  valid_wdata;
   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_W-1:0]     mem_addr;
   logic [DATA_W-1:0]     mem_wdata;
   logic                  mem_ack;
   logic [DATA_W-1:0]     mem_rdata;

   modport master (
      output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
             tag_rdata, valid_rdata, data_rdata, mem_ack, mem_rdata,
      input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, arr_index,
             arr_write, line_sel, tag_wdata, data_wdata, valid_wdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
             tag_rdata, valid_rdata, data_rdata, mem_ack, mem_rdata,
      output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata, arr_index,
             arr_write, line_sel, tag_wdata, data_wdata, valid_wdata,
             mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/cache_ctrl_fsm.sv
// Controller for an 8-line direct-mapped write-through, no-write-allocate cache.
// Define CACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module cache_ctrl_fsm #(
   parameter int ADDR_W = 32,
   parameter int TAG_W  = 26,
   parameter int IDX_W  = 3,
   parameter int DATA_W = 8
) (
   input  logic            clk,
   input  logic            reset,
   cache_ctrl_fsm_if.slave bus
`ifdef CACHE_STATS_EN
   ,
   output logic [15:0]     hit_count,
   output logic [15:0]     miss_count
`endif
);
   localparam int LINES = 2**IDX_W;

   typedef enum logic [2:0] {
      S_IDLE, S_COMPARE, S_MEM_READ, S_REFILL, S_MEM_WRITE, S_RESPOND
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;

   logic [TAG_W-1:0]    req_tag;
   logic [IDX_W-1:0]    req_idx;
   logic [LINES-1:0]    req_onehot;
   logic                hit;

   logic                ready;
   logic                resp_valid;
   logic [DATA_W-1:0]   resp_rdata;
   logic                arr_write;
   logic [LINES-1:0]    line_sel;
   logic [TAG_W-1:0]    tag_wdata;
   logic [DATA_W-1:0]   data_wdata;
   logic                valid_wdata;
   logic                mem_req;
   logic                mem_we;
   logic [DATA_W-1:0]   mem_wdata;

   assign req_tag    = addr_q[ADDR_W-1 -: TAG_W];
   assign req_idx    = addr_q[IDX_W+2:3];
   assign req_onehot = {{(LINES-1){1'b0}}, 1'b1} << req_idx;
   assign hit        = bus.valid_rdata && (bus.tag_rdata == req_tag);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         we_q    <= we_d;
         rdata_q <= rdata_d;
      end
   end

   // rdata_q carries the hit data, the refill data, or the store data echoed back.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_d    = we_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (bus.cpu_req_valid) begin
               addr_d  = bus.cpu_req_addr;
               wdata_d = bus.cpu_req_wdata;
               we_d    = bus.cpu_req_we;
               state_d = S_COMPARE;
            end
         end
         S_COMPARE: begin
            if (we_q) begin
               rdata_d = wdata_q;
               state_d = S_MEM_WRITE;
            end else if (hit) begin
               rdata_d = bus.data_rdata;
               state_d = S_RESPOND;
            end else begin
               state_d = S_MEM_READ;
            end
         end
         S_MEM_READ: begin
            if (bus.mem_ack) begin
               rdata_d = bus.mem_rdata;
               state_d = S_REFILL;
            end
         end
         S_REFILL:    state_d = S_RESPOND;
         S_MEM_WRITE: if (bus.mem_ack) state_d = S_RESPOND;
         S_RESPOND:   state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // Write-side outputs are zeroed outside their strobe so line_sel never leaks a decode.
   always_comb begin
      ready       = 1'b0;
      resp_valid  = 1'b0;
      resp_rdata  = '0;
      arr_write   = 1'b0;
      line_sel    = '0;
      tag_wdata   = '0;
      data_wdata  = '0;
      valid_wdata = 1'b0;
      mem_req     = 1'b0;
      mem_we      = 1'b0;
      mem_wdata   = '0;
      case (state_q)
         S_IDLE: ready = 1'b1;
         S_COMPARE: begin
            if (we_q && hit) begin
               arr_write   = 1'b1;
               line_sel    = req_onehot;
               tag_wdata   = req_tag;
               data_wdata  = wdata_q;
               valid_wdata = 1'b1;
            end
         end
         S_MEM_READ: mem_req = 1'b1;
         S_REFILL: begin
            arr_write   = 1'b1;
            line_sel    = req_onehot;
            tag_wdata   = req_tag;
            data_wdata  = rdata_q;
            valid_wdata = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_wdata = wdata_q;
         end
         S_RESPOND: begin
            resp_valid = 1'b1;
            resp_rdata = rdata_q;
         end
         default: ;
      endcase
   end

   assign bus.cpu_req_ready  = ready;
   assign bus.cpu_resp_valid = resp_valid;
   assign bus.cpu_resp_rdata = resp_rdata;
   assign bus.arr_index      = req_idx;
   assign bus.arr_write      = arr_write;
   assign bus.line_sel       = line_sel;
   assign bus.tag_wdata      = tag_wdata;
   assign bus.data_wdata     = data_wdata;
   assign bus.valid_wdata    = valid_wdata;
   assign bus.mem_req        = mem_req;
   assign bus.mem_we         = mem_we;
   assign bus.mem_addr       = addr_q;
   assign bus.mem_wdata      = mem_wdata;

`ifdef CACHE_STATS_EN
   logic [15:0] hit_cnt_q, hit_cnt_d;
   logic [15:0] miss_cnt_q, miss_cnt_d;

   always_comb begin
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      if (state_q == S_COMPARE) begin
         if (hit && (hit_cnt_q != 16'hFFFF))
            hit_cnt_d = hit_cnt_q + 16'd1;
         if (!hit && (miss_cnt_q != 16'hFFFF))
            miss_cnt_d = miss_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif
endmodule
